// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the domain reset sequencer.
// Reused by the per-domain reset normalizer instantiations.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ASSERT    = 2'd0,
        WAIT_INIT = 2'd1,
        READY     = 2'd2,
        ERROR     = 2'd3
    } seq_state_e;

    localparam int SEQ_COUNT_W        = 8;
    localparam int DEF_ASSERT_CYCLES  = 32;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_counter.sv
// seq_cycle_counter: clear-to-zero cycle counter with terminal flag.
// tc is high while the count equals TERM-1.
module seq_cycle_counter
    import reset_seq_pkg::*;
#(
    parameter int TERM = 32
) (
    input  logic clk,
    input  logic resetn,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int W = cnt_width(TERM);

    logic [W-1:0] count;

    // Load returns the count to zero and wins over counting.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == W'(TERM - 1));

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: timed domain reset pulse, init wait, ready flag.
// RESET_SEQ_AUTO_RETRY_EN adds automatic retries and retry_cnt.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_DOMAINS      = 4,
    parameter int ASSERT_CYCLES  = DEF_ASSERT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   req_reset,
    input  logic [N_DOMAINS-1:0]   init_done,
    output logic                   domain_resetn,
    output logic                   busy,
    output logic                   sys_ready,
    output logic                   timeout_err,
`ifdef RESET_SEQ_AUTO_RETRY_EN
    output logic [cnt_width(MAX_RETRIES+1)-1:0] retry_cnt,
`endif
    output logic [SEQ_COUNT_W-1:0] seq_count
);

    localparam int RETRY_W = cnt_width(MAX_RETRIES + 1);

`ifdef RESET_SEQ_AUTO_RETRY_EN
    localparam bit AUTO_RETRY = 1'b1;
`else
    localparam bit AUTO_RETRY = 1'b0;
`endif

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic               a_tc;
    logic               t_tc;
    logic               cnt_load;
    logic               to_err;
    logic               do_retry;
    logic               retry_ok;
    logic               enter_ready;
    logic [RETRY_W-1:0] retry_q;

    // Both counters restart from zero on every state change.
    assign cnt_load = (state_d != state_q);

    seq_cycle_counter #(
        .TERM (ASSERT_CYCLES)
    ) u_assert_cnt (
        .clk    (clk),
        .resetn (resetn),
        .load   (cnt_load),
        .en     (state_q == ASSERT),
        .tc     (a_tc)
    );

    seq_cycle_counter #(
        .TERM (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .resetn (resetn),
        .load   (cnt_load),
        .en     (state_q == WAIT_INIT),
        .tc     (t_tc)
    );

    assign retry_ok = AUTO_RETRY &&
                      (retry_q != RETRY_W'(MAX_RETRIES));

    // Next state; a restart request beats completion and timeout.
    always_comb begin
        state_d  = state_q;
        to_err   = 1'b0;
        do_retry = 1'b0;
        unique case (state_q)
            ASSERT: begin
                if (a_tc) state_d = WAIT_INIT;
            end
            WAIT_INIT: begin
                if (req_reset) begin
                    state_d = ASSERT;
                end else if (&init_done) begin
                    state_d = READY;
                end else if (t_tc) begin
                    if (retry_ok) begin
                        state_d  = ASSERT;
                        do_retry = 1'b1;
                    end else begin
                        state_d = ERROR;
                        to_err  = 1'b1;
                    end
                end
            end
            READY: begin
                if (req_reset) state_d = ASSERT;
            end
            ERROR: begin
                if (req_reset) state_d = ASSERT;
            end
            default: state_d = ASSERT;
        endcase
    end

    assign enter_ready = (state_d == READY) && (state_q != READY);

    // State register and registered domain reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ASSERT;
            domain_resetn <= 1'b0;
        end else begin
            state_q       <= state_d;
            domain_resetn <= (state_d != ASSERT);
        end
    end

    // Sticky timeout flag, dropped by the request that leaves ERROR.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            timeout_err <= 1'b0;
        end else if (to_err) begin
            timeout_err <= 1'b1;
        end else if (req_reset && state_q == ERROR) begin
            timeout_err <= 1'b0;
        end
    end

    // Completed-sequence count, saturating at all ones.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            seq_count <= '0;
        end else if (enter_ready && seq_count != '1) begin
            seq_count <= seq_count + SEQ_COUNT_W'(1);
        end
    end

    // Retry count; stays at zero when auto retry is not built in.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            retry_q <= '0;
        end else if (enter_ready ||
                     (req_reset && state_q != ASSERT)) begin
            retry_q <= '0;
        end else if (do_retry) begin
            retry_q <= retry_q + RETRY_W'(1);
        end
    end

`ifdef RESET_SEQ_AUTO_RETRY_EN
    assign retry_cnt = retry_q;
`endif

    assign busy      = (state_q == ASSERT) || (state_q == WAIT_INIT);
    assign sys_ready = (state_q == READY);

endmodule
